// File: rtl/gol_pkg.sv
// Shared definitions for the cell-grid stamping blocks: default grid size,
// stamp mode encodings, FSM state encoding and the per-cell update rule.
package gol_pkg;

  localparam int MAX_X_DEF = 64;
  localparam int MAX_Y_DEF = 48;

  typedef enum logic [1:0] {
    MODE_SET     = 2'b00,
    MODE_CLEAR   = 2'b01,
    MODE_TOGGLE  = 2'b10,
    MODE_REPLACE = 2'b11
  } stamp_mode_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic apply_mode(input logic [1:0] mode, input logic old_bit,
                                      input logic pat_bit);
    logic res;
    case (stamp_mode_e'(mode))
      MODE_SET:    res = old_bit | pat_bit;
      MODE_CLEAR:  res = old_bit & ~pat_bit;
      MODE_TOGGLE: res = old_bit ^ pat_bit;
      default:     res = pat_bit;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gol_wrap_addr.sv
// Toroidal address generator: cursor plus pattern offset, wrapped on both axes,
// flattened row-major into a cell address.
module gol_wrap_addr
  import gol_pkg::*;
#(
  parameter int MAX_X  = MAX_X_DEF,
  parameter int MAX_Y  = MAX_Y_DEF,
  parameter int DX_W   = 3,
  parameter int DY_W   = 3,
  parameter int ADDR_W = 12
) (
  input  logic [7:0]        cursor_x,
  input  logic [7:0]        cursor_y,
  input  logic [DX_W-1:0]   dx,
  input  logic [DY_W-1:0]   dy,
  output logic [ADDR_W-1:0] addr
);

  localparam int SUM_W = 10;

  logic [SUM_W-1:0] sum_x, sum_y, nx, ny;

  // Cursor is range-checked upstream and offsets never exceed the grid, so a
  // single conditional subtract is a full modulo.
  assign sum_x = SUM_W'(cursor_x) + SUM_W'(dx);
  assign sum_y = SUM_W'(cursor_y) + SUM_W'(dy);
  assign nx    = (sum_x >= SUM_W'(MAX_X)) ? sum_x - SUM_W'(MAX_X) : sum_x;
  assign ny    = (sum_y >= SUM_W'(MAX_Y)) ? sum_y - SUM_W'(MAX_Y) : sum_y;
  assign addr  = ADDR_W'(ny) * ADDR_W'(MAX_X) + ADDR_W'(nx);

endmodule

// File: rtl/pattern_stamper.sv
// Stamps a PAT_W x PAT_H bit pattern onto a toroidal cell grid by read-modify-write,
// tracking the live-cell count. Macro STAMP_ROTATE_EN adds 90-degree pattern rotation.
module pattern_stamper
  import gol_pkg::*;
#(
  parameter int MAX_X  = MAX_X_DEF,
  parameter int MAX_Y  = MAX_Y_DEF,
  parameter int PAT_W  = 8,
  parameter int PAT_H  = 8,
  parameter int CNT_W  = 12,
  parameter int ADDR_W = $clog2(MAX_X * MAX_Y)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [1:0]             rot,
  input  logic [7:0]             cursor_x,
  input  logic [7:0]             cursor_y,
  input  logic [PAT_W*PAT_H-1:0] pattern_mat,
  input  logic [CNT_W-1:0]       alives_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       alives_out,
  output logic [ADDR_W-1:0]      cell_addr,
  input  logic                   cell_rd_data,
  output logic                   cell_wr_en,
  output logic [ADDR_W-1:0]      cell_wr_addr,
  output logic                   cell_wr_data
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | one cell read per cycle; each write trails its read by one cycle
  // DRAIN | final write lands
  // DONE  | one-cycle completion pulse, alives_out valid

  localparam int DX_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int DY_W  = (PAT_H > 1) ? $clog2(PAT_H) : 1;
  localparam int IDX_W = (PAT_W * PAT_H > 1) ? $clog2(PAT_W * PAT_H) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]             state;
  logic [1:0]             mode_q;
  logic [7:0]             cx_q, cy_q;
  logic [PAT_W*PAT_H-1:0] pat_q;
  logic [DX_W-1:0]        dx;
  logic [DY_W-1:0]        dy;
  logic [CNT_W-1:0]       cnt, cnt_next, alives_q;
  logic                   err_q;
  logic                   pipe_valid, pipe_bit;
  logic [ADDR_W-1:0]      pipe_addr, rd_addr;
  logic [IDX_W-1:0]       pat_idx;
  logic                   pat_bit, new_bit, wr_en, range_bad, last_cell;

  gol_wrap_addr #(
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y),
    .DX_W  (DX_W),
    .DY_W  (DY_W),
    .ADDR_W(ADDR_W)
  ) u_wrap (
    .cursor_x(cx_q),
    .cursor_y(cy_q),
    .dx      (dx),
    .dy      (dy),
    .addr    (rd_addr)
  );

`ifdef STAMP_ROTATE_EN
  logic [1:0] rot_q;
  int         px, py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rot_q <= '0;
    else if (state == ST_IDLE && start)
      rot_q <= rot;
  end

  // Square patterns only, so source coordinates stay inside the pattern.
  always_comb begin
    px = int'(dx);
    py = int'(dy);
    case (rot_q)
      2'd1: begin px = int'(dy);             py = PAT_W - 1 - int'(dx); end
      2'd2: begin px = PAT_W - 1 - int'(dx); py = PAT_H - 1 - int'(dy); end
      2'd3: begin px = PAT_H - 1 - int'(dy); py = int'(dx);             end
      default: ;
    endcase
    pat_idx = IDX_W'(py * PAT_W + px);
  end
`else
  logic unused_rot;
  assign unused_rot = ^rot;
  assign pat_idx    = IDX_W'(int'(dy) * PAT_W + int'(dx));
`endif

  assign pat_bit   = pat_q[pat_idx];
  assign range_bad = (int'(cursor_x) >= MAX_X) || (int'(cursor_y) >= MAX_Y);
  assign last_cell = (dx == DX_W'(PAT_W - 1)) && (dy == DY_W'(PAT_H - 1));
  assign new_bit   = apply_mode(mode_q, cell_rd_data, pipe_bit);
  assign wr_en     = pipe_valid && (new_bit != cell_rd_data);

  always_comb begin
    cnt_next = cnt;
    if (wr_en) begin
      if (new_bit && cnt != CNT_MAX)
        cnt_next = cnt + CNT_W'(1);
      else if (!new_bit && cnt != '0)
        cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      pat_q      <= '0;
      dx         <= '0;
      dy         <= '0;
      cnt        <= '0;
      alives_q   <= '0;
      err_q      <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_bit   <= 1'b0;
      pipe_addr  <= '0;
    end else begin
      pipe_valid <= (state == ST_READ);
      if (state == ST_READ) begin
        pipe_addr <= rd_addr;
        pipe_bit  <= pat_bit;
      end
      cnt <= cnt_next;

      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode;
            cx_q   <= cursor_x;
            cy_q   <= cursor_y;
            pat_q  <= pattern_mat;
            cnt    <= alives_in;
            dx     <= '0;
            dy     <= '0;
            err_q  <= range_bad;
            if (range_bad) begin
              alives_q <= alives_in;
              state    <= ST_DONE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (dx == DX_W'(PAT_W - 1)) begin
            dx <= '0;
            dy <= dy + DY_W'(1);
          end else begin
            dx <= dx + DX_W'(1);
          end
          if (last_cell)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          alives_q <= cnt_next;
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state == ST_READ) || (state == ST_DRAIN);
  assign done         = (state == ST_DONE);
  assign err          = err_q;
  assign alives_out   = alives_q;
  assign cell_addr    = (state == ST_READ) ? rd_addr : '0;
  assign cell_wr_en   = wr_en;
  assign cell_wr_addr = pipe_addr;
  assign cell_wr_data = pipe_valid & new_bit;

endmodule

// File: tb/tb_pattern_stamper.sv
// Self-checking bench for pattern_stamper: grid memory model, shadow-grid
// scoreboard of expected writes, and one task per scenario.
module tb_pattern_stamper;

  localparam int MX = 64;
  localparam int MY = 48;
  localparam int PW = 8;
  localparam int PH = 8;
  localparam int CW = 12;
  localparam int AW = 12;
  localparam int NC = MX * MY;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    rot = 2'd0;
  logic [7:0]    cursor_x = 8'd0;
  logic [7:0]    cursor_y = 8'd0;
  logic [63:0]   pattern_mat = 64'd0;
  logic [CW-1:0] alives_in = '0;
  logic          busy, done, err;
  logic [CW-1:0] alives_out;
  logic [AW-1:0] cell_addr, cell_wr_addr;
  logic          cell_rd_data = 1'b0;
  logic          cell_wr_en, cell_wr_data;

  typedef struct {int addr; logic data;} wr_t;
  wr_t exp_q[$];
  wr_t mon_w;

  logic grid_mem [0:NC-1];
  logic shadow   [0:NC-1];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  int r_done_cyc, r_alv, r_busy, r_ndone, r_addr_nz, r_wr;
  logic r_err;
  int p_alv, p_nwr;

  pattern_stamper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rot(rot),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .pattern_mat(pattern_mat),
    .alives_in(alives_in), .busy(busy), .done(done), .err(err),
    .alives_out(alives_out), .cell_addr(cell_addr), .cell_rd_data(cell_rd_data),
    .cell_wr_en(cell_wr_en), .cell_wr_addr(cell_wr_addr), .cell_wr_data(cell_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NC; i++) begin
      grid_mem[i] = 1'b0;
      shadow[i]   = 1'b0;
    end
  end

  always @(posedge clk) begin
    cell_rd_data <= grid_mem[cell_addr];
    if (cell_wr_en) grid_mem[cell_wr_addr] <= cell_wr_data;
  end

  // Scoreboard consumer: every observed write must match the next predicted one.
  always @(negedge clk) begin
    if (rst_n && cell_wr_en === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=%0d, none expected", cell_wr_addr, cell_wr_data);
      end else begin
        mon_w = exp_q.pop_front();
        if (cell_wr_addr !== AW'(mon_w.addr) || cell_wr_data !== mon_w.data) begin
          errors++;
          $display("FAIL wr_match: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   cell_wr_addr, cell_wr_data, mon_w.addr, mon_w.data);
        end
      end
    end
  end

  function automatic int shadow_pop();
    int n = 0;
    for (int i = 0; i < NC; i++) if (shadow[i]) n++;
    return n;
  endfunction

  // Reference model: walks the pattern, updates the shadow grid, queues writes.
  task automatic predict(input logic [1:0] m, input logic [1:0] r, input int cx, input int cy,
                         input logic [63:0] pat, input int ain);
    int cnt, sx, sy, a;
    logic p, o, nv;
    cnt = ain;
    p_nwr = 0;
    for (int y = 0; y < PH; y++) begin
      for (int x = 0; x < PW; x++) begin
        sx = x; sy = y;
`ifdef STAMP_ROTATE_EN
        case (r)
          2'd1: begin sx = y;          sy = PW - 1 - x; end
          2'd2: begin sx = PW - 1 - x; sy = PH - 1 - y; end
          2'd3: begin sx = PH - 1 - y; sy = x;          end
          default: ;
        endcase
`else
        if (r == 2'd0) sx = x;
`endif
        p = pat[sy*PW+sx];
        a = ((cy + y) % MY) * MX + ((cx + x) % MX);
        o = shadow[a];
        case (m)
          2'd0: nv = o | p;
          2'd1: nv = o & ~p;
          2'd2: nv = o ^ p;
          default: nv = p;
        endcase
        if (nv != o) begin
          exp_q.push_back('{a, nv});
          shadow[a] = nv;
          p_nwr++;
          if (nv) cnt = (cnt == 4095) ? 4095 : cnt + 1;
          else    cnt = (cnt == 0) ? 0 : cnt - 1;
        end
      end
    end
    p_alv = cnt;
  endtask

  task automatic do_stamp(input logic [1:0] m, input logic [1:0] r, input int cx, input int cy,
                          input logic [63:0] pat, input int ain, input bit b2b);
    int wr0;
    wr0 = wr_seen;
    r_done_cyc = -1; r_alv = -1; r_err = 1'bx;
    r_busy = 0; r_ndone = 0; r_addr_nz = 0;
    @(negedge clk);
    mode = m; rot = r; cursor_x = 8'(cx); cursor_y = 8'(cy);
    pattern_mat = pat; alives_in = CW'(ain); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done) begin
        r_ndone++;
        if (r_done_cyc < 0) begin
          r_done_cyc = c; r_alv = int'(alives_out); r_err = err;
        end
      end
      if (busy) r_busy++;
      if (cell_addr != '0) r_addr_nz++;
      if (b2b && c == 4) begin
        start = 1'b1; cursor_x = 8'd0; cursor_y = 8'd40; mode = 2'd3; pattern_mat = '1;
      end
      if (b2b && c == 5) start = 1'b0;
    end
    r_wr = wr_seen - wr0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, cell_wr_en} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, cell_wr_en});
    end
    checks++;
    if (cell_addr !== '0 || cell_wr_addr !== '0 || cell_wr_data !== 1'b0) begin
      errors++; $display("FAIL reset_addr: got %0d/%0d/%0d expected 0/0/0", cell_addr, cell_wr_addr, cell_wr_data);
    end
    checks++;
    if (alives_out !== '0) begin
      errors++; $display("FAIL reset_alives: got %0d expected 0", alives_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glider();
    logic [63:0] pat;
    pat = '0;
    pat[1] = 1'b1; pat[10] = 1'b1; pat[16] = 1'b1; pat[17] = 1'b1; pat[18] = 1'b1;
    predict(2'd0, 2'd0, 10, 10, pat, 0);
    do_stamp(2'd0, 2'd0, 10, 10, pat, 0, 1'b0);
    checks++; if (r_done_cyc !== 66) begin errors++; $display("FAIL glider_done_cycle: got %0d expected 66", r_done_cyc); end
    checks++; if (r_alv !== 5) begin errors++; $display("FAIL glider_alives: got %0d expected 5", r_alv); end
    checks++; if (r_wr !== 5) begin errors++; $display("FAIL glider_writes: got %0d expected 5", r_wr); end
    checks++; if (r_busy !== 65) begin errors++; $display("FAIL glider_busy_cycles: got %0d expected 65", r_busy); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL glider_err: got %b expected 0", r_err); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL glider_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int ain;
    ain = shadow_pop();
    predict(2'd0, 2'd0, 60, 46, '1, ain);
    do_stamp(2'd0, 2'd0, 60, 46, '1, ain, 1'b0);
    checks++; if (r_alv !== ain + 64) begin errors++; $display("FAIL wrap_alives: got %0d expected %0d", r_alv, ain + 64); end
    checks++; if (r_wr !== 64) begin errors++; $display("FAIL wrap_writes: got %0d expected 64", r_wr); end
    checks++;
    if ({grid_mem[5*MX+3], grid_mem[47*MX+63], grid_mem[0], grid_mem[5*MX+4], grid_mem[46*MX+59]} !== 5'b11100) begin
      errors++; $display("FAIL wrap_cells: got %b expected 11100",
                         {grid_mem[5*MX+3], grid_mem[47*MX+63], grid_mem[0], grid_mem[5*MX+4], grid_mem[46*MX+59]});
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wrap_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_toggle_twice();
    logic saved [0:63];
    logic [63:0] pat;
    int ain, diff;
    pat = {$urandom, $urandom};
    ain = shadow_pop();
    for (int i = 0; i < 64; i++) saved[i] = grid_mem[(20 + i / 8) * MX + 20 + i % 8];
    predict(2'd2, 2'd0, 20, 20, pat, ain);
    do_stamp(2'd2, 2'd0, 20, 20, pat, ain, 1'b0);
    checks++; if (r_alv !== p_alv) begin errors++; $display("FAIL toggle1_alives: got %0d expected %0d", r_alv, p_alv); end
    predict(2'd2, 2'd0, 20, 20, pat, r_alv);
    do_stamp(2'd2, 2'd0, 20, 20, pat, r_alv, 1'b0);
    checks++; if (r_alv !== ain) begin errors++; $display("FAIL toggle2_alives: got %0d expected %0d", r_alv, ain); end
    diff = 0;
    for (int i = 0; i < 64; i++) if (grid_mem[(20 + i / 8) * MX + 20 + i % 8] !== saved[i]) diff++;
    checks++; if (diff !== 0) begin errors++; $display("FAIL toggle_restore: got %0d differing cells expected 0", diff); end
  endtask

  task automatic test_clear_empty();
    int ain;
    ain = shadow_pop();
    predict(2'd1, 2'd0, 30, 30, '1, ain);
    do_stamp(2'd1, 2'd0, 30, 30, '1, ain, 1'b0);
    checks++; if (r_wr !== 0) begin errors++; $display("FAIL clear_writes: got %0d expected 0", r_wr); end
    checks++; if (r_alv !== ain) begin errors++; $display("FAIL clear_alives: got %0d expected %0d", r_alv, ain); end
  endtask

  task automatic test_err();
    do_stamp(2'd0, 2'd0, 64, 0, '1, 123, 1'b0);
    checks++; if (r_done_cyc !== 1) begin errors++; $display("FAIL err_done_cycle: got %0d expected 1", r_done_cyc); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", r_err); end
    checks++; if (r_alv !== 123) begin errors++; $display("FAIL err_alives: got %0d expected 123", r_alv); end
    checks++;
    if (r_wr !== 0 || r_addr_nz !== 0 || r_busy !== 0) begin
      errors++; $display("FAIL err_activity: got wr=%0d addr=%0d busy=%0d expected 0/0/0", r_wr, r_addr_nz, r_busy);
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    do_stamp(2'd0, 2'd0, 0, 48, '1, 7, 1'b0);
    checks++;
    if (r_done_cyc !== 1 || r_err !== 1'b1) begin
      errors++; $display("FAIL err_y: got done=%0d err=%b expected 1/1", r_done_cyc, r_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pat;
    int ain;
    pat = 64'h00FF_0F0F_3C3C_8001;
    ain = shadow_pop();
    predict(2'd0, 2'd0, 50, 10, pat, ain);
    do_stamp(2'd0, 2'd0, 50, 10, pat, ain, 1'b1);
    checks++; if (r_ndone !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", r_ndone); end
    checks++; if (r_done_cyc !== 66) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 66", r_done_cyc); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL b2b_err_cleared: got %b expected 0", r_err); end
    checks++; if (r_alv !== p_alv) begin errors++; $display("FAIL b2b_alives: got %0d expected %0d", r_alv, p_alv); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    predict(2'd0, 2'd0, 40, 30, '1, 4090);
    do_stamp(2'd0, 2'd0, 40, 30, '1, 4090, 1'b0);
    checks++; if (r_alv !== 4095) begin errors++; $display("FAIL sat_high: got %0d expected 4095", r_alv); end
    predict(2'd1, 2'd0, 40, 30, '1, 3);
    do_stamp(2'd1, 2'd0, 40, 30, '1, 3, 1'b0);
    checks++; if (r_alv !== 0) begin errors++; $display("FAIL sat_low: got %0d expected 0", r_alv); end
    checks++; if (r_wr !== 64) begin errors++; $display("FAIL sat_clear_writes: got %0d expected 64", r_wr); end
  endtask

  task automatic test_rotation();
    logic [63:0] pat;
    int ain;
    logic [3:0] cells;
    pat = '0;
    pat[0] = 1'b1; pat[8] = 1'b1; pat[16] = 1'b1; pat[17] = 1'b1;
    ain = shadow_pop();
    predict(2'd0, 2'd1, 10, 20, pat, ain);
    do_stamp(2'd0, 2'd1, 10, 20, pat, ain, 1'b0);
`ifdef STAMP_ROTATE_EN
    cells = {grid_mem[1297], grid_mem[1296], grid_mem[1295], grid_mem[1359]};
`else
    cells = {grid_mem[20*MX+10], grid_mem[21*MX+10], grid_mem[22*MX+10], grid_mem[22*MX+11]};
`endif
    checks++; if (cells !== 4'b1111) begin errors++; $display("FAIL rot_cells: got %b expected 1111", cells); end
    checks++; if (r_wr !== 4) begin errors++; $display("FAIL rot_writes: got %0d expected 4", r_wr); end
    checks++; if (r_alv !== ain + 4) begin errors++; $display("FAIL rot_alives: got %0d expected %0d", r_alv, ain + 4); end
  endtask

  task automatic test_reset_midstamp();
    int wr0, ones, nd;
    wr0 = wr_seen;
    predict(2'd0, 2'd0, 30, 40, '1, shadow_pop());
    @(negedge clk);
    mode = 2'd0; rot = 2'd0; cursor_x = 8'd30; cursor_y = 8'd40; pattern_mat = '1;
    alives_in = CW'(shadow_pop()); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, cell_wr_en, done} !== 3'b000) begin
      errors++; $display("FAIL abort_outputs: got %b expected 000", {busy, cell_wr_en, done});
    end
    checks++; if (alives_out !== '0) begin errors++; $display("FAIL abort_alives: got %0d expected 0", alives_out); end
    checks++; if (wr_seen - wr0 !== 18) begin errors++; $display("FAIL abort_writes: got %0d expected 18", wr_seen - wr0); end
    while (exp_q.size() > 0) begin
      mon_w = exp_q.pop_front();
      shadow[mon_w.addr] = ~mon_w.data;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
    ones = 0;
    for (int i = 0; i < 64; i++) if (grid_mem[(40 + i / 8) * MX + 30 + i % 8]) ones++;
    checks++; if (ones !== 18) begin errors++; $display("FAIL abort_cells: got %0d expected 18", ones); end
  endtask

  task automatic test_consistency();
    int diff = 0;
    for (int i = 0; i < NC; i++) if (grid_mem[i] !== shadow[i]) diff++;
    checks++; if (diff !== 0) begin errors++; $display("FAIL grid_consistency: got %0d differing cells expected 0", diff); end
  endtask

  initial begin
    test_reset();
    test_glider();
    test_wrap();
    test_toggle_twice();
    test_clear_empty();
    test_err();
    test_back_to_back();
    test_saturation();
    test_rotation();
    test_reset_midstamp();
    test_consistency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
